spi_master_fsm: RTL
===================

Name: spi_master_fsm

Overview:
SPI initiator that produces the frames our SPI memory responder consumes. The host issues a single-cycle start command with an address, a direction bit and write data. The block drives cs, sclk and mosi, samples miso, and returns the read data with a one-cycle done pulse. It sits between an on-chip host (test sequencer or CPU bus bridge) and the off-block SPI pins.

Parameters:
CLK_DIV, 2, clk cycles per sclk half-period; legal values are 1 and above.
READ_GAP, 2, idle sclk periods between header and read data, giving the responder time to load its shift register.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high.
start  input  1  single-cycle command strobe; sampled only in IDLE.
rw  input  1  1 = read, 0 = write; captured with start.
addr  input  7  target address; captured with start.
wdata  input  8  write data; captured with start.
busy  output  1  high from the cycle after start is accepted until done, inclusive.
done  output  1  one-cycle pulse at end of frame.
rdata  output  8  last read byte; updates only on a read's done cycle.
cs  output  1  chip select, active-low.
sclk  output  1  SPI clock; idle low.
mosi  output  1  serial data to responder.
miso  input  1  serial data from responder.

Behaviour:
- Reset values and IDLE outputs: cs=1, sclk=0, mosi=0, busy=0, done=0, rdata=8'h00, state=IDLE, all counters 0.
- Frame format, MSB first: header {addr[6:0], rw} (8 bits), then for a read READ_GAP gap periods, then 8 data bits.
- Bit timing: mosi changes only while sclk is low. The responder samples on sclk rising. The master samples miso in the clk cycle in which it drives sclk high.
- Each sclk period is CLK_DIV cycles high followed by CLK_DIV cycles low.
- States and transitions:
  - IDLE: start=1 latches rw/addr/wdata and goes to SETUP.
  - SETUP: cs=0, sclk=0, mosi=header[7], held CLK_DIV cycles; then HEADER.
  - HEADER: 8 sclk periods shifting out the header. Exit to GAP if rw=1 and READ_GAP>0, to RDATA if rw=1 and READ_GAP=0, and to WDATA if rw=0.
  - GAP: READ_GAP sclk periods with mosi=0, then RDATA.
  - WDATA: 8 periods shifting out wdata, then FINISH.
  - RDATA: 8 periods with mosi=0, shifting miso into an internal shift register, then FINISH.
  - FINISH: cs=1, sclk=0, mosi=0, done=1 for exactly one cycle. On a read, rdata loads the shift register in this cycle. Then IDLE.
- Latency, measured from the clk edge that samples start (edge 0) to the edge at which done is high:
  - write: CLK_DIV*33 + 1
  - read: CLK_DIV*(33 + 2*READ_GAP) + 1
- start while busy is ignored; there is no queueing. start in the done cycle is ignored. start in the first IDLE cycle after done is accepted.
- Reset mid-frame: on the next edge cs=1 and sclk=0, no done pulse is produced, and rdata is cleared to 0.
- Input changes on rw/addr/wdata after acceptance have no effect on the frame in progress.
- Counters are sized for at least CLK_DIV-1 (half-period count) and 8+READ_GAP (bit count). There is no wrap inside a frame.

Optional Feature:
SPI_CS_HOLD_EN:
- Defined: between the last sclk low phase and FINISH, insert a HOLD state of CLK_DIV cycles with cs=0, sclk=0, mosi=0. Both latencies grow by CLK_DIV.
- Undefined: no HOLD state; cs rises in FINISH as above.

Test Plan:
- Write, CLK_DIV=2: start, rw=0, addr=7'h15, wdata=8'hA5.
  - mosi bits sampled at the 16 sclk rising edges are 0010101_0 then 10100101.
  - cs low throughout the frame; done at cycle 67; rdata stays 0.
- Read, CLK_DIV=2, READ_GAP=2: start, rw=1, addr=7'h2A; responder model drives 8'h3C on miso after the gap.
  - header = 0101010_1; done at cycle 75; rdata=8'h3C; busy low the cycle after done.
- Ignored start: start pulsed at cycle 10 of an active write with different addr/wdata.
  - Frame is unchanged; only one done pulse.
- Reset mid-frame: reset at cycle 20 of a read.
  - Next cycle cs=1, sclk=0, busy=0, rdata=0; done never pulses.
  - A new write started afterwards completes normally.
- Back-to-back and minimum divider, CLK_DIV=1:
  - start held high continuously → frames separated by exactly 2 idle cycles (FINISH and the IDLE acceptance cycle).
  - Write done at cycle 34.
- SPI_CS_HOLD_EN defined, CLK_DIV=2 write: cs stays low 2 extra cycles after the last falling sclk; done at cycle 69.

Source files
------------

// File: rtl/spi_master_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master_fsm_if
//  Purpose  : Host command/response bus plus SPI pin bundle for spi_master_fsm.
//  Revision : 1.0  initial release
//
//  Signals:
//    start  host -> master  single-cycle command strobe
//    rw     host -> master  1 = read, 0 = write
//    addr   host -> master  7-bit target address
//    wdata  host -> master  write data byte
//    busy   master -> host  frame in progress (through done cycle)
//    done   master -> host  one-cycle end-of-frame pulse
//    rdata  master -> host  last read byte
//    cs     master -> pins  chip select, active-low
//    sclk   master -> pins  SPI clock, idle low
//    mosi   master -> pins  serial data out
//    miso   pins -> master  serial data in
//
//  Modports: master (the initiator), slave (host/responder side).
// ============================================================================
interface spi_master_fsm_if;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       cs;
  logic       sclk;
  logic       mosi;
  logic       miso;

  modport master (
    input  start, rw, addr, wdata, miso,
    output busy, done, rdata, cs, sclk, mosi
  );

  modport slave (
    output start, rw, addr, wdata, miso,
    input  busy, done, rdata, cs, sclk, mosi
  );
endinterface
`default_nettype wire

// File: rtl/spi_master_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master_fsm
//  Purpose  : SPI initiator (mode 0, MSB first). Sends header {addr, rw},
//             then either a write byte or, after READ_GAP idle sclk periods,
//             captures a read byte from miso.
//  Revision : 1.0  initial release
//
//  Ports:
//    clk    system clock, all logic on posedge
//    reset  synchronous, active-high
//    bus    spi_master_fsm_if.master (host command/response + SPI pins)
//
//  Parameters:
//    CLK_DIV   clk cycles per sclk half-period (>= 1)
//    READ_GAP  idle sclk periods between header and read data
//
//  Build option:
//    SPI_CS_HOLD_EN  inserts a HOLD state of CLK_DIV cycles (cs low, sclk low)
//                    between the last sclk low phase and FINISH.
// ============================================================================
module spi_master_fsm #(
  parameter int CLK_DIV  = 2,
  parameter int READ_GAP = 2
) (
  input  wire logic         clk,
  input  wire logic         reset,
  spi_master_fsm_if.master  bus
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(8 + READ_GAP + 1);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_SETUP  = 3'd1;
  localparam logic [2:0] c_ST_HEADER = 3'd2;
  localparam logic [2:0] c_ST_GAP    = 3'd3;
  localparam logic [2:0] c_ST_WDATA  = 3'd4;
  localparam logic [2:0] c_ST_RDATA  = 3'd5;
  localparam logic [2:0] c_ST_HOLD   = 3'd6;
  localparam logic [2:0] c_ST_FINISH = 3'd7;

  localparam logic [HW-1:0] c_HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [BW-1:0] c_BYTE_LAST = BW'(7);
  localparam logic [BW-1:0] c_GAP_LAST  = BW'((READ_GAP > 0) ? READ_GAP - 1 : 0);
  localparam logic [2:0]    c_READ_NEXT = (READ_GAP > 0) ? c_ST_GAP : c_ST_RDATA;
`ifdef SPI_CS_HOLD_EN
  localparam logic [2:0]    c_DATA_NEXT = c_ST_HOLD;
`else
  localparam logic [2:0]    c_DATA_NEXT = c_ST_FINISH;
`endif

  logic [2:0]    r_state;
  logic [HW-1:0] r_hcnt;   // cycles elapsed in current half-period
  logic          r_phase;  // 0 = sclk high half, 1 = sclk low half
  logic [BW-1:0] r_bcnt;   // sclk periods completed in current state
  logic          r_rw;
  logic [7:0]    r_wdata;
  logic [7:0]    r_tx;     // mosi is always r_tx[7]
  logic [7:0]    r_rx;
  logic [7:0]    r_rdata;

  logic          w_half_end;
  logic          w_bit_state;
  logic          w_active;
  logic          w_last_bit;
  logic [2:0]    w_next;

  assign w_half_end  = (r_hcnt == c_HALF_LAST);
  assign w_bit_state = (r_state == c_ST_HEADER) || (r_state == c_ST_GAP) ||
                       (r_state == c_ST_WDATA)  || (r_state == c_ST_RDATA);
  assign w_active    = (r_state != c_ST_IDLE) && (r_state != c_ST_FINISH);
  assign w_last_bit  = (r_state == c_ST_GAP) ? (r_bcnt == c_GAP_LAST)
                                             : (r_bcnt == c_BYTE_LAST);

  always_comb begin
    w_next = c_DATA_NEXT;
    case (r_state)
      c_ST_HEADER: w_next = r_rw ? c_READ_NEXT : c_ST_WDATA;
      c_ST_GAP:    w_next = c_ST_RDATA;
      default:     w_next = c_DATA_NEXT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
      r_hcnt  <= '0;
      r_phase <= 1'b0;
      r_bcnt  <= '0;
      r_rw    <= 1'b0;
      r_wdata <= 8'h00;
      r_tx    <= 8'h00;
      r_rx    <= 8'h00;
      r_rdata <= 8'h00;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (bus.start) begin
            r_rw    <= bus.rw;
            r_wdata <= bus.wdata;
            r_tx    <= {bus.addr, bus.rw};
            r_hcnt  <= '0;
            r_state <= c_ST_SETUP;
          end
        end

        c_ST_SETUP: begin
          if (w_half_end) begin
            r_hcnt  <= '0;
            r_phase <= 1'b0;
            r_bcnt  <= '0;
            r_state <= c_ST_HEADER;
          end else begin
            r_hcnt <= r_hcnt + HW'(1);
          end
        end

        c_ST_HEADER, c_ST_GAP, c_ST_WDATA, c_ST_RDATA: begin
          if (!w_half_end) begin
            r_hcnt <= r_hcnt + HW'(1);
          end else begin
            r_hcnt <= '0;
            if (!r_phase) begin
              // Falling sclk: mosi advances here so it is stable at the next rise.
              // After the last header bit the write byte is preloaded; every
              // other stream ends with mosi held low.
              r_phase <= 1'b1;
              if (w_last_bit)
                r_tx <= (r_state == c_ST_HEADER && !r_rw) ? r_wdata : 8'h00;
              else
                r_tx <= {r_tx[6:0], 1'b0};
            end else begin
              r_phase <= 1'b0;
              if (w_last_bit) begin
                r_bcnt  <= '0;
                r_state <= w_next;
              end else begin
                r_bcnt <= r_bcnt + BW'(1);
              end
            end
          end
          // miso is captured at the end of the first clk cycle with sclk high.
          if (r_state == c_ST_RDATA && !r_phase && r_hcnt == '0)
            r_rx <= {r_rx[6:0], bus.miso};
        end

`ifdef SPI_CS_HOLD_EN
        c_ST_HOLD: begin
          if (w_half_end) begin
            r_hcnt  <= '0;
            r_state <= c_ST_FINISH;
          end else begin
            r_hcnt <= r_hcnt + HW'(1);
          end
        end
`endif

        c_ST_FINISH: begin
          if (r_rw)
            r_rdata <= r_rx;
          r_state <= c_ST_IDLE;
        end

        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign bus.cs    = ~w_active;
  assign bus.sclk  = w_bit_state & ~r_phase;
  assign bus.mosi  = w_active & r_tx[7];
  assign bus.busy  = (r_state != c_ST_IDLE);
  assign bus.done  = (r_state == c_ST_FINISH);
  assign bus.rdata = r_rdata;

endmodule
`default_nettype wire
